// File: rtl/msh_rd_dp.sv
// msh_rd_dp: mesh read datapath -- takes tagged reads, issues them to a fixed-latency bank, returns them in order.
// Optional feature macro MSH_RD_DP_PAR_EN adds per-entry even-parity storage and an o_rrsp_perr flag.
module msh_rd_dp #(
  parameter int ADDR_W    = 14,
  parameter int DATA_W    = 64,
  parameter int TAG_W     = 8,
  parameter int MEM_LAT   = 2,
  parameter int RSP_DEPTH = 8
) (
  input  logic              mclk,
  input  logic              mrst,
  input  logic              i_rreq_vld,
  output logic              o_rreq_rdy,
  input  logic [ADDR_W-1:0] i_rreq_addr,
  input  logic [TAG_W-1:0]  i_rreq_tag,
  output logic              o_mem_ren,
  output logic [ADDR_W-1:0] o_mem_raddr,
  input  logic [DATA_W-1:0] i_mem_rdata,
`ifdef MSH_RD_DP_PAR_EN
  input  logic              i_mem_rpar,
`endif
  output logic              o_rrsp_vld,
  input  logic              i_rrsp_rdy,
  output logic [DATA_W-1:0] o_rrsp_data,
  output logic [TAG_W-1:0]  o_rrsp_tag,
`ifdef MSH_RD_DP_PAR_EN
  output logic              o_rrsp_perr,
`endif
  output logic              o_rd_idle
);

  localparam int RESV_W = $clog2(RSP_DEPTH + 1);
  localparam int PTR_W  = $clog2(RSP_DEPTH);
  localparam logic [RESV_W-1:0] RESV_MAX = RESV_W'(RSP_DEPTH);
  localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(RSP_DEPTH - 1);

  typedef struct packed {
`ifdef MSH_RD_DP_PAR_EN
    logic              par;
`endif
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } rsp_ent_t;

  logic [MEM_LAT:0]  tp_vld_q, tp_vld_d;
  logic [TAG_W-1:0]  tp_tag_q [MEM_LAT+1];
  logic [TAG_W-1:0]  tp_tag_d [MEM_LAT+1];
  logic [ADDR_W-1:0] mem_raddr_q, mem_raddr_d;
  logic [RESV_W-1:0] resv_q, resv_d;
  logic [RESV_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0]  wptr_q, wptr_d;
  logic [PTR_W-1:0]  rptr_q, rptr_d;
  rsp_ent_t          fifo_q [RSP_DEPTH];
  rsp_ent_t          fifo_d [RSP_DEPTH];
  rsp_ent_t          wr_ent;
  rsp_ent_t          head;
  logic              accept;
  logic              fifo_wr;
  logic              fifo_pop;
  logic              fifo_empty;
  logic              fifo_full;

  // Ready depends only on the reservation count, so a pop frees a slot one cycle later.
  assign o_rreq_rdy = ~mrst & (resv_q < RESV_MAX);

  always_comb begin
    accept      = i_rreq_vld & o_rreq_rdy;
    fifo_empty  = (cnt_q == '0);
    fifo_full   = (cnt_q == RESV_MAX);
    fifo_wr     = tp_vld_q[MEM_LAT];
    fifo_pop    = ~fifo_empty & i_rrsp_rdy;

    tp_vld_d    = {tp_vld_q[MEM_LAT-1:0], accept};
    tp_tag_d[0] = i_rreq_tag;
    for (int k = 1; k <= MEM_LAT; k++) begin
      tp_tag_d[k] = tp_tag_q[k-1];
    end

    mem_raddr_d = accept ? i_rreq_addr : mem_raddr_q;

    wr_ent      = '0;
    wr_ent.data = i_mem_rdata;
    wr_ent.tag  = tp_tag_q[MEM_LAT];
`ifdef MSH_RD_DP_PAR_EN
    wr_ent.par  = i_mem_rpar;
`endif

    fifo_d = fifo_q;
    if (fifo_wr) begin
      fifo_d[wptr_q] = wr_ent;
    end

    wptr_d = wptr_q;
    if (fifo_wr) begin
      wptr_d = (wptr_q == PTR_LAST) ? '0 : wptr_q + PTR_W'(1);
    end
    rptr_d = rptr_q;
    if (fifo_pop) begin
      rptr_d = (rptr_q == PTR_LAST) ? '0 : rptr_q + PTR_W'(1);
    end

    unique case ({fifo_wr, fifo_pop})
      2'b10:   cnt_d = cnt_q + RESV_W'(1);
      2'b01:   cnt_d = cnt_q - RESV_W'(1);
      default: cnt_d = cnt_q;
    endcase

    unique case ({accept, fifo_pop})
      2'b10:   resv_d = resv_q + RESV_W'(1);
      2'b01:   resv_d = resv_q - RESV_W'(1);
      default: resv_d = resv_q;
    endcase
  end

  // Reset clears every valid in the tag pipe, so bank data still in flight is never captured.
  always_ff @(posedge mclk) begin
    if (mrst) begin
      tp_vld_q    <= '0;
      mem_raddr_q <= '0;
      resv_q      <= '0;
      cnt_q       <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
    end else begin
      tp_vld_q    <= tp_vld_d;
      mem_raddr_q <= mem_raddr_d;
      resv_q      <= resv_d;
      cnt_q       <= cnt_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
    end
  end

  always_ff @(posedge mclk) begin
    tp_tag_q <= tp_tag_d;
    fifo_q   <= fifo_d;
  end

  assign head        = fifo_q[rptr_q];
  assign o_mem_ren   = tp_vld_q[0];
  assign o_mem_raddr = mem_raddr_q;
  assign o_rrsp_vld  = ~fifo_empty;
  assign o_rrsp_data = o_rrsp_vld ? head.data : '0;
  assign o_rrsp_tag  = o_rrsp_vld ? head.tag : '0;
  assign o_rd_idle   = (resv_q == '0);
`ifdef MSH_RD_DP_PAR_EN
  assign o_rrsp_perr = o_rrsp_vld & ((^head.data) != head.par);
`endif

  a_no_ovfl: assert property (@(posedge mclk) disable iff (mrst) !(fifo_wr && fifo_full));
  a_resv_rng: assert property (@(posedge mclk) disable iff (mrst) resv_q <= RESV_MAX);
  a_cnt_le_resv: assert property (@(posedge mclk) disable iff (mrst) cnt_q <= resv_q);

endmodule

// File: tb/tb_msh_rd_dp.sv
// Directed bench for msh_rd_dp: a bank model with fixed latency and a scoreboard of expected responses.
// Build both files with MSH_RD_DP_PAR_EN defined to cover the parity path as well.
module tb_msh_rd_dp;

  localparam int ADDR_W    = 14;
  localparam int DATA_W    = 64;
  localparam int TAG_W     = 8;
  localparam int MEM_LAT   = 2;
  localparam int RSP_DEPTH = 8;
  localparam logic [ADDR_W-1:0] FLIP_ADDR = 14'h0BAD;

  logic              mclk = 1'b0;
  logic              mrst;
  logic              i_rreq_vld;
  logic              o_rreq_rdy;
  logic [ADDR_W-1:0] i_rreq_addr;
  logic [TAG_W-1:0]  i_rreq_tag;
  logic              o_mem_ren;
  logic [ADDR_W-1:0] o_mem_raddr;
  logic [DATA_W-1:0] i_mem_rdata;
  logic              o_rrsp_vld;
  logic              i_rrsp_rdy;
  logic [DATA_W-1:0] o_rrsp_data;
  logic [TAG_W-1:0]  o_rrsp_tag;
  logic              o_rd_idle;
`ifdef MSH_RD_DP_PAR_EN
  logic              i_mem_rpar;
  logic              o_rrsp_perr;
`endif

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
    logic              perr;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   vec_cnt = 0;
  int   err_cnt = 0;
  int   pop_cnt = 0;
  int   acc;

  msh_rd_dp #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W), .MEM_LAT(MEM_LAT), .RSP_DEPTH(RSP_DEPTH)
  ) dut (
    .mclk        (mclk),
    .mrst        (mrst),
    .i_rreq_vld  (i_rreq_vld),
    .o_rreq_rdy  (o_rreq_rdy),
    .i_rreq_addr (i_rreq_addr),
    .i_rreq_tag  (i_rreq_tag),
    .o_mem_ren   (o_mem_ren),
    .o_mem_raddr (o_mem_raddr),
    .i_mem_rdata (i_mem_rdata),
`ifdef MSH_RD_DP_PAR_EN
    .i_mem_rpar  (i_mem_rpar),
`endif
    .o_rrsp_vld  (o_rrsp_vld),
    .i_rrsp_rdy  (i_rrsp_rdy),
    .o_rrsp_data (o_rrsp_data),
    .o_rrsp_tag  (o_rrsp_tag),
`ifdef MSH_RD_DP_PAR_EN
    .o_rrsp_perr (o_rrsp_perr),
`endif
    .o_rd_idle   (o_rd_idle)
  );

  initial forever #5 mclk = ~mclk;

  function automatic logic [DATA_W-1:0] mem_fn(input logic [ADDR_W-1:0] a);
    if (a == 14'h0010) return 64'h0123_4567_89AB_CDEF;
    return {4{2'b10, a}} ^ 64'h5A5A_0000_0000_A5A5;
  endfunction

  // Bank model: the address seen with o_mem_ren returns MEM_LAT cycles later.
  logic [ADDR_W-1:0] mp_addr [MEM_LAT];
  always @(posedge mclk) begin
    mp_addr[0] <= o_mem_raddr;
    for (int k = 1; k < MEM_LAT; k++) mp_addr[k] <= mp_addr[k-1];
  end
  assign i_mem_rdata = mem_fn(mp_addr[MEM_LAT-1]);
`ifdef MSH_RD_DP_PAR_EN
  assign i_mem_rpar = (^i_mem_rdata) ^ (mp_addr[MEM_LAT-1] == FLIP_ADDR);
`endif

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge mclk);
    #1;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (!o_rd_idle && n < budget) begin
      step();
      n++;
    end
    chk(tag, 128'(o_rd_idle), 128'(1));
  endtask

  // Response monitor: every cycle with a valid head is compared to the oldest expected entry.
  always @(negedge mclk) begin
    if (mrst) begin
      sb.delete();
    end else begin
      if (o_rrsp_vld) begin
        chk("rsp_expected", 128'(sb.size() != 0), 128'(1));
        if (sb.size() != 0) begin
          chk("rsp_tag", 128'(o_rrsp_tag), 128'(sb[0].tag));
          chk("rsp_data", 128'(o_rrsp_data), 128'(sb[0].data));
`ifdef MSH_RD_DP_PAR_EN
          chk("rsp_perr", 128'(o_rrsp_perr), 128'(sb[0].perr));
`endif
          if (i_rrsp_rdy) begin
            void'(sb.pop_front());
            pop_cnt++;
          end
        end
      end
      if (i_rreq_vld && o_rreq_rdy) begin
        mon_e.tag  = i_rreq_tag;
        mon_e.data = mem_fn(i_rreq_addr);
        mon_e.perr = (i_rreq_addr == FLIP_ADDR);
        sb.push_back(mon_e);
      end
    end
  end

  initial begin
    mrst        = 1'b1;
    i_rreq_vld  = 1'b0;
    i_rreq_addr = '0;
    i_rreq_tag  = '0;
    i_rrsp_rdy  = 1'b0;
    repeat (3) step();

    chk("rst_rreq_rdy", 128'(o_rreq_rdy), 128'(0));
    chk("rst_mem_ren", 128'(o_mem_ren), 128'(0));
    chk("rst_mem_raddr", 128'(o_mem_raddr), 128'(0));
    chk("rst_rrsp_vld", 128'(o_rrsp_vld), 128'(0));
    chk("rst_rrsp_data", 128'(o_rrsp_data), 128'(0));
    chk("rst_rrsp_tag", 128'(o_rrsp_tag), 128'(0));
    chk("rst_idle", 128'(o_rd_idle), 128'(1));
    mrst = 1'b0;
    #1;
    chk("post_rst_rdy", 128'(o_rreq_rdy), 128'(1));

    // Single read, minimum latency
    i_rrsp_rdy  = 1'b1;
    i_rreq_vld  = 1'b1;
    i_rreq_addr = 14'h0010;
    i_rreq_tag  = 8'h05;
    step();
    i_rreq_vld = 1'b0;
    chk("t1_mem_ren", 128'(o_mem_ren), 128'(1));
    chk("t1_mem_raddr", 128'(o_mem_raddr), 128'(14'h0010));
    chk("t1_busy", 128'(o_rd_idle), 128'(0));
    step();
    step();
    chk("t1_vld_early", 128'(o_rrsp_vld), 128'(0));
    step();
    chk("t1_vld", 128'(o_rrsp_vld), 128'(1));
    chk("t1_tag", 128'(o_rrsp_tag), 128'(8'h05));
    chk("t1_data", 128'(o_rrsp_data), 128'(64'h0123_4567_89AB_CDEF));
    step();
    chk("t1_idle", 128'(o_rd_idle), 128'(1));
    chk("t1_vld_gone", 128'(o_rrsp_vld), 128'(0));

    // Streaming: 20 back-to-back reads with an always-ready sink
    for (int i = 0; i < 20; i++) begin
      i_rreq_vld  = 1'b1;
      i_rreq_addr = ADDR_W'(14'h0100 + i);
      i_rreq_tag  = TAG_W'(i);
      chk("t2_rdy", 128'(o_rreq_rdy), 128'(1));
      if (i >= 4) chk("t2_rsp_vld", 128'(o_rrsp_vld), 128'(1));
      step();
    end
    i_rreq_vld = 1'b0;
    for (int j = 0; j < 4; j++) begin
      chk("t2_rsp_vld_tail", 128'(o_rrsp_vld), 128'(1));
      step();
    end
    chk("t2_vld_done", 128'(o_rrsp_vld), 128'(0));
    chk("t2_idle", 128'(o_rd_idle), 128'(1));
    chk("t2_pops", 128'(pop_cnt), 128'(21));

    // Backpressure: only RSP_DEPTH requests fit, head holds until the sink is ready
    i_rrsp_rdy = 1'b0;
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      i_rreq_vld  = 1'b1;
      i_rreq_addr = ADDR_W'(14'h0200 + i);
      i_rreq_tag  = TAG_W'(8'h40 + i);
      if (o_rreq_rdy) acc++;
      step();
    end
    i_rreq_vld = 1'b0;
    chk("t3_accepted", 128'(acc), 128'(8));
    chk("t3_rdy_full", 128'(o_rreq_rdy), 128'(0));
    chk("t3_head_vld", 128'(o_rrsp_vld), 128'(1));
    chk("t3_head_tag", 128'(o_rrsp_tag), 128'(8'h40));
    repeat (3) step();
    chk("t3_hold_tag", 128'(o_rrsp_tag), 128'(8'h40));
    chk("t3_hold_data", 128'(o_rrsp_data), 128'(mem_fn(14'h0200)));
    i_rrsp_rdy = 1'b1;
    #1;
    chk("t3_rdy_no_comb", 128'(o_rreq_rdy), 128'(0));
    step();
    chk("t3_rdy_after_pop", 128'(o_rreq_rdy), 128'(1));
    wait_idle("t3_drain", 50);
    chk("t3_pops", 128'(pop_cnt), 128'(29));

    // Simultaneous accept and pop with seven reservations outstanding
    i_rrsp_rdy = 1'b0;
    for (int i = 0; i < 7; i++) begin
      i_rreq_vld  = 1'b1;
      i_rreq_addr = ADDR_W'(14'h0300 + i);
      i_rreq_tag  = TAG_W'(8'h60 + i);
      step();
    end
    i_rreq_vld = 1'b0;
    repeat (5) step();
    chk("t4_resv_pre", 128'(dut.resv_q), 128'(7));
    i_rrsp_rdy  = 1'b1;
    i_rreq_vld  = 1'b1;
    i_rreq_addr = 14'h0307;
    i_rreq_tag  = 8'h67;
    step();
    i_rreq_vld = 1'b0;
    chk("t4_resv_hold", 128'(dut.resv_q), 128'(7));
    chk("t4_rdy_hold", 128'(o_rreq_rdy), 128'(1));
    wait_idle("t4_drain", 50);
    chk("t4_pops", 128'(pop_cnt), 128'(37));

    // Reset with three reads in flight and two in the FIFO
    i_rrsp_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      i_rreq_vld  = 1'b1;
      i_rreq_addr = ADDR_W'(14'h0400 + i);
      i_rreq_tag  = TAG_W'(8'h80 + i);
      step();
    end
    i_rreq_vld = 1'b0;
    chk("t5_fifo_busy", 128'(o_rrsp_vld), 128'(1));
    mrst = 1'b1;
    step();
    mrst = 1'b0;
    #1;
    chk("t5_idle", 128'(o_rd_idle), 128'(1));
    chk("t5_rdy", 128'(o_rreq_rdy), 128'(1));
    chk("t5_data_clr", 128'(o_rrsp_data), 128'(0));
    chk("t5_tag_clr", 128'(o_rrsp_tag), 128'(0));
    i_rrsp_rdy = 1'b1;
    for (int j = 0; j < 10; j++) begin
      chk("t5_no_stale", 128'(o_rrsp_vld), 128'(0));
      step();
    end
    chk("t5_pops", 128'(pop_cnt), 128'(37));

`ifdef MSH_RD_DP_PAR_EN
    // Parity: second read comes back with inverted parity
    chk("t6_perr_idle", 128'(o_rrsp_perr), 128'(0));
    i_rreq_vld  = 1'b1;
    i_rreq_addr = 14'h0500;
    i_rreq_tag  = 8'hA0;
    step();
    i_rreq_addr = FLIP_ADDR;
    i_rreq_tag  = 8'hA1;
    step();
    i_rreq_vld = 1'b0;
    wait_idle("t6_drain", 50);
    chk("t6_pops", 128'(pop_cnt), 128'(39));
`endif

    chk("sb_empty", 128'(sb.size()), 128'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
